// File: rtl/mmu_sequencer_if.sv
// Host/feeder signal bundle for the MMU sequencer.
// The host (master) streams bytes in; the sequencer (slave) stages them and drives the feeder.
interface mmu_sequencer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       cfg_transpose;
    logic       abort;
    logic [7:0] weight0;
    logic [7:0] weight1;
    logic [7:0] weight2;
    logic [7:0] weight3;
    logic [7:0] input0;
    logic [7:0] input1;
    logic [7:0] input2;
    logic [7:0] input3;
    logic       mmu_en;
    logic [2:0] mmu_cycle;
    logic       transpose;
    logic       out_valid;
    logic [1:0] out_index;
    logic       busy;

    modport master (
        output in_valid, in_data, cfg_transpose, abort,
        input  in_ready, weight0, weight1, weight2, weight3,
               input0, input1, input2, input3,
               mmu_en, mmu_cycle, transpose, out_valid, out_index, busy
    );

    modport slave (
        input  in_valid, in_data, cfg_transpose, abort,
        output in_ready, weight0, weight1, weight2, weight3,
               input0, input1, input2, input3,
               mmu_en, mmu_cycle, transpose, out_valid, out_index, busy
    );
endinterface

// File: rtl/mmu_sequencer.sv
// Collects eight host bytes into weight/input staging registers and sequences a
// seven-phase feeder run, prefetching the next operation's bytes during phases 3..6.
module mmu_sequencer (
    input  logic              clk,
    input  logic              rst,
    mmu_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] loadCount_q, loadCount_d;
    logic [2:0] cycle_q, cycle_d;
    logic       transpose_q, transpose_d;
    logic [7:0] stage_q [8];
    logic [7:0] stage_d [8];

    logic       inReady;
    logic       accept;
    logic       outValid;
    logic [2:0] resultPhase;

    // The feeder stops reading staging after phase 2, so bytes may land from phase 3 on.
    assign inReady     = (state_q != RUN) || (cycle_q >= 3'd3);
    assign accept      = bus.in_valid && inReady;
    assign outValid    = (state_q == RUN) && (cycle_q >= 3'd2) && (cycle_q <= 3'd5);
    assign resultPhase = cycle_q - 3'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            loadCount_q <= 4'd0;
            cycle_q     <= 3'd0;
            transpose_q <= 1'b0;
            stage_q     <= '{default: 8'h00};
        end else begin
            state_q     <= state_d;
            loadCount_q <= loadCount_d;
            cycle_q     <= cycle_d;
            transpose_q <= transpose_d;
            stage_q     <= stage_d;
        end
    end

    // Abort wins over both byte acceptance and phase advance; staging and transpose hold.
    always_comb begin
        state_d     = state_q;
        loadCount_d = loadCount_q;
        cycle_d     = cycle_q;
        transpose_d = transpose_q;
        stage_d     = stage_q;

        if (bus.abort) begin
            state_d     = IDLE;
            loadCount_d = 4'd0;
            cycle_d     = 3'd0;
        end else begin
            if (accept) begin
                stage_d[loadCount_q[2:0]] = bus.in_data;
                loadCount_d               = loadCount_q + 4'd1;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (accept && (loadCount_q == 4'd7)) begin
                        state_d     = RUN;
                        loadCount_d = 4'd0;
                        cycle_d     = 3'd0;
                        transpose_d = bus.cfg_transpose;
                    end
                end
                RUN: begin
                    if (cycle_q == 3'd6) begin
                        cycle_d = 3'd0;
                        state_d = (loadCount_d != 4'd0) ? LOAD : IDLE;
                    end else begin
                        cycle_d = cycle_q + 3'd1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    loadCount_d = 4'd0;
                    cycle_d     = 3'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.weight0   = stage_q[0];
    assign bus.weight1   = stage_q[1];
    assign bus.weight2   = stage_q[2];
    assign bus.weight3   = stage_q[3];
    assign bus.input0    = stage_q[4];
    assign bus.input1    = stage_q[5];
    assign bus.input2    = stage_q[6];
    assign bus.input3    = stage_q[7];
    assign bus.mmu_en    = (state_q == RUN);
    assign bus.mmu_cycle = cycle_q;
    assign bus.transpose = transpose_q;
    assign bus.out_valid = outValid;
    assign bus.out_index = outValid ? resultPhase[1:0] : 2'd0;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/mmu_sequencer.md
MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  host byte strobe.
REQ-004 SHALL have port: in_data  input  8  host byte.
REQ-005 SHALL have port: in_ready  output  1  sequencer accepts in_data this cycle.
REQ-006 SHALL have port: cfg_transpose  input  1  transpose request for the pending operation.
REQ-007 SHALL have port: abort  input  1  synchronous cancel.
REQ-008 SHALL have ports: weight0..weight3  output  8 each  staged weight bytes to feeder.
REQ-009 SHALL have ports: input0..input3  output  8 each  staged input bytes to feeder.
REQ-010 SHALL have port: mmu_en  output  1  feeder enable.
REQ-011 SHALL have port: mmu_cycle  output  3  feeder phase counter.
REQ-012 SHALL have port: transpose  output  1  latched transpose for the running operation.
REQ-013 SHALL have port: out_valid  output  1  result byte valid on feeder host_outdata.
REQ-014 SHALL have port: out_index  output  2  result element index: 0=c00, 1=c01, 2=c10, 3=c11.
REQ-015 SHALL have port: busy  output  1  state not IDLE.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN.
REQ-017 SHALL keep load_count 0..8 (4 bits) and map byte slots in order: 0-3 to weight0-3, 4-7 to input0-3.
REQ-018 SHALL accept a byte when in_valid && in_ready, write it to slot load_count, and increment load_count by 1.
REQ-019 SHALL drive in_ready=1 in IDLE and LOAD, in RUN only when mmu_cycle>=3, and 0 otherwise.
REQ-020 IDLE: accepted byte -> LOAD, load_count=1; in_valid low -> stay IDLE.
REQ-021 LOAD: on acceptance of slot 7 -> RUN next cycle with mmu_cycle=0 and load_count=0; latch transpose=cfg_transpose on that same edge.
REQ-022 RUN: mmu_en=1; mmu_cycle SHALL advance 0,1,2,3,4,5,6, one step per clock, independent of in_valid.
REQ-023 RUN bytes accepted at mmu_cycle 3..6 SHALL overwrite slots from 0 upward (prefetch); feeder does not read staging registers after cycle 2.
REQ-024 At end of mmu_cycle 6 SHALL go to LOAD if load_count>0 (prefetched count retained), else IDLE; mmu_cycle returns to 0, mmu_en to 0.
REQ-025 SHALL drive out_valid = mmu_en && 2<=mmu_cycle<=5 and out_index = mmu_cycle-2 (2 LSBs); out_index=0 when out_valid=0.
REQ-026 End-to-end latency: slot 7 accepted at edge N -> mmu_cycle=0 at N, first out_valid at N+2, last at N+5, IDLE/LOAD at N+7.
REQ-027 SHALL keep mmu_en=0 and mmu_cycle=0 in IDLE and LOAD.
REQ-028 abort=1 SHALL, at next edge, force IDLE, load_count=0, mmu_cycle=0, mmu_en=0, with priority over acceptance and phase advance; staging registers and transpose hold their values.
REQ-029 in_valid while in_ready=0 SHALL be ignored; no byte is stored or counted.
REQ-030 Staging registers SHALL change only on an accepted byte or reset.

Reset
REQ-031 rst SHALL immediately force IDLE, load_count=0, mmu_cycle=0, mmu_en=0, transpose=0, all weight/input registers=0; outputs out_valid=0, out_index=0, busy=0, in_ready=1.
REQ-032 rst asserted mid-RUN SHALL abandon the operation with no further out_valid pulses.

Verification
REQ-033 Bytes 1..8 on consecutive cycles, cfg_transpose=1 -> weight0..3=1..4, input0..3=5..8, transpose=1, mmu_cycle 0..6 over 7 cycles, out_valid for 4 cycles with out_index 0,1,2,3.
REQ-034 Bytes with gaps (in_valid low 3 cycles between slots 3 and 4) -> still LOAD, load_count holds 4, RUN starts only after slot 7.
REQ-035 In RUN, present bytes 0xA0..0xA5 continuously from mmu_cycle 0 -> in_ready low for cycles 0-2, 0xA0..0xA3 land in weight0..3 at cycles 3-6, next state LOAD with load_count=4.
REQ-036 abort at mmu_cycle=3 -> next cycle IDLE, mmu_en=0, out_valid=0, staging registers unchanged.
REQ-037 rst pulse at mmu_cycle=1 -> all outputs at reset values asynchronously; after release, 8 new bytes run a complete operation normally.
REQ-038 in_valid held during RUN cycles 0-2 -> no write, load_count unchanged.
